// File: rtl/axi_fft_pkg.sv
// axi_fft_pkg: sample width and {IM, RE} stream packing shared by the FFT input and output stages.
package axi_fft_pkg;
    localparam int SAMPLE_W = 32;
    localparam int TDATA_W  = 2 * SAMPLE_W;

    function automatic logic [TDATA_W-1:0] pack_sample(input logic [SAMPLE_W-1:0] im, input logic [SAMPLE_W-1:0] re);
        return {im, re};
    endfunction
endpackage

// File: rtl/fft_sample_ram.sv
// fft_sample_ram: sample store with synchronous write and two asynchronous read ports (RE and IM word).
module fft_sample_ram
    import axi_fft_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                we,
    input  logic [AW-1:0]       waddr,
    input  logic [SAMPLE_W-1:0] wdata,
    input  logic [AW-1:0]       raddr_a,
    input  logic [AW-1:0]       raddr_b,
    output logic [SAMPLE_W-1:0] rdata_a,
    output logic [SAMPLE_W-1:0] rdata_b
);
    logic [SAMPLE_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata_a = mem[raddr_a];
    assign rdata_b = mem[raddr_b];
endmodule

// File: rtl/fft_data_input.sv
// fft_data_input: buffers one frame of complex samples and streams it as {IM, RE} beats over AXI-Stream.
module fft_data_input
    import axi_fft_pkg::*;
#(
    parameter int NFFT = 8
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       wEn,
    input  logic [$clog2(NFFT*2)-1:0]  wAddr,
    input  logic [SAMPLE_W-1:0]        wData,
    input  logic                       start,
    output logic                       tvalid,
    input  logic                       tready,
    output logic                       tlast,
    output logic [TDATA_W-1:0]         tdata,
    output logic                       sending,
    output logic                       done
);
    localparam int AW = $clog2(NFFT * 2);
    localparam int IW = $clog2(NFFT);
    localparam logic IDLE    = 1'b0;
    localparam logic SENDING = 1'b1;

    logic          state, state_n;
    logic [IW-1:0] i, i_n;
    logic          done_n;
    logic [SAMPLE_W-1:0] re, im;

    // The RAM is frozen while a frame is streaming so beats never mix old and new samples.
    fft_sample_ram #(.DEPTH(NFFT * 2)) u_ram (
        .clk     (clk),
        .we      (wEn && state == IDLE),
        .waddr   (wAddr),
        .wdata   (wData),
        .raddr_a ({i, 1'b0}),
        .raddr_b ({i, 1'b1}),
        .rdata_a (re),
        .rdata_b (im)
    );

    assign sending = state == SENDING;
    assign tvalid  = sending;
    assign tlast   = sending && i == IW'(NFFT - 1);
    assign tdata   = pack_sample(im, re);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
            i     <= '0;
            done  <= 1'b0;
        end else begin
            state <= state_n;
            i     <= i_n;
            done  <= done_n;
        end
    end

    always_comb begin
        state_n = state;
        i_n     = i;
        done_n  = 1'b0;
        if (state == IDLE) begin
            if (start) begin
                state_n = SENDING;
                i_n     = '0;
            end
        end else if (tready) begin
            state_n = tlast ? IDLE : SENDING;
            i_n     = tlast ? '0 : i + 1'b1;
            done_n  = tlast;
        end
    end
endmodule

// File: tb/tb_fft_data_input.sv
// tb_fft_data_input: directed checks of frame streaming, stalls, start/write corner cases and reset abort.
module tb_fft_data_input;
    logic        clk = 1'b0;
    logic        resetn = 1'b1;
    logic        wEn = 1'b0;
    logic [3:0]  wAddr = '0;
    logic [31:0] wData = '0;
    logic        start = 1'b0;
    logic        tready = 1'b0;
    logic        tvalid, tlast, sending, done;
    logic [63:0] tdata;

    logic [31:0] mem [16];
    int checks = 0;
    int errors = 0;

    fft_data_input #(.NFFT(8)) dut (
        .clk     (clk),
        .resetn  (resetn),
        .wEn     (wEn),
        .wAddr   (wAddr),
        .wData   (wData),
        .start   (start),
        .tvalid  (tvalid),
        .tready  (tready),
        .tlast   (tlast),
        .tdata   (tdata),
        .sending (sending),
        .done    (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic write_word(input int addr, input logic [31:0] val, input bit takes);
        wEn = 1'b1;
        wAddr = 4'(addr);
        wData = val;
        @(negedge clk);
        wEn = 1'b0;
        if (takes) mem[addr] = val;
    endtask

    task automatic start_frame();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("start_latency", {63'b0, tvalid}, 64'd1);
    endtask

    // Called at a negedge where beat 0 is presented; runs the frame to its end.
    task automatic run_frame(input bit alt, input int stall0, input bit start_at3, input bit start_on_done, input int stop_at);
        int k = 0;
        int cyc = 0;
        tready = 1'b0;
        for (int s = 0; s < stall0; s++) begin
            chk("stall0_valid", {63'b0, tvalid}, 64'd1);
            chk("stall0_data", tdata, {mem[1], mem[0]});
            chk("stall0_last", {63'b0, tlast}, 64'd0);
            @(negedge clk);
        end
        while (k < 8 && cyc < 100) begin
            if (k == stop_at) return;
            chk($sformatf("beat%0d_valid", k), {63'b0, tvalid}, 64'd1);
            chk($sformatf("beat%0d_data", k), tdata, {mem[2*k+1], mem[2*k]});
            chk($sformatf("beat%0d_last", k), {63'b0, tlast}, {63'b0, k == 7});
            chk($sformatf("beat%0d_done", k), {63'b0, done}, 64'd0);
            tready = alt ? (cyc % 2 == 1) : 1'b1;
            start = start_at3 && k == 3;
            @(negedge clk);
            if (tready) k++;
            cyc++;
        end
        start = 1'b0;
        if (cyc >= 100) chk("frame_timeout", 64'(cyc), 64'd0);
        chk("end_done", {63'b0, done}, 64'd1);
        chk("end_valid", {63'b0, tvalid}, 64'd0);
        chk("end_sending", {63'b0, sending}, 64'd0);
        start = start_on_done;
        @(negedge clk);
        start = 1'b0;
        chk("post_done", {63'b0, done}, 64'd0);
        chk("post_valid", {63'b0, tvalid}, {63'b0, start_on_done});
    endtask

    initial begin
        #1 resetn = 1'b0;
        #1;
        chk("rst_valid", {63'b0, tvalid}, 64'd0);
        chk("rst_last", {63'b0, tlast}, 64'd0);
        chk("rst_sending", {63'b0, sending}, 64'd0);
        chk("rst_done", {63'b0, done}, 64'd0);
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        chk("idle_valid", {63'b0, tvalid}, 64'd0);

        for (int a = 0; a < 16; a++) write_word(a, 32'h100 + 32'(a), 1'b1);

        start_frame();
        run_frame(1'b0, 0, 1'b0, 1'b0, -1);

        start_frame();
        run_frame(1'b1, 0, 1'b0, 1'b0, -1);

        start_frame();
        tready = 1'b0;
        write_word(3, 32'hDEAD, 1'b0);
        run_frame(1'b0, 0, 1'b0, 1'b0, -1);
        start_frame();
        chk("ignored_write_im1", 64'(mem[3]), 64'h103);
        run_frame(1'b0, 0, 1'b0, 1'b0, -1);

        start_frame();
        run_frame(1'b0, 0, 1'b1, 1'b1, -1);
        run_frame(1'b0, 0, 1'b0, 1'b0, -1);

        start_frame();
        run_frame(1'b0, 20, 1'b0, 1'b0, -1);

        wEn = 1'b1;
        wAddr = 4'd0;
        wData = 32'h55;
        mem[0] = 32'h55;
        start_frame();
        wEn = 1'b0;
        run_frame(1'b0, 0, 1'b0, 1'b0, -1);

        start_frame();
        run_frame(1'b0, 0, 1'b0, 1'b0, 4);
        chk("pre_abort_data", tdata, {mem[9], mem[8]});
        #2 resetn = 1'b0;
        #1;
        chk("abort_valid", {63'b0, tvalid}, 64'd0);
        chk("abort_last", {63'b0, tlast}, 64'd0);
        chk("abort_sending", {63'b0, sending}, 64'd0);
        @(negedge clk);
        chk("abort_done", {63'b0, done}, 64'd0);
        resetn = 1'b1;
        @(negedge clk);
        chk("abort_idle_done", {63'b0, done}, 64'd0);
        chk("abort_idle_valid", {63'b0, tvalid}, 64'd0);
        start_frame();
        run_frame(1'b0, 0, 1'b0, 1'b0, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
